// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single imem read port between compressed-instruction fetch and the token loader.
// Fetch has fixed priority; a saturating wait counter forces a loader win after STARVE_LIMIT waits.
module imem_fetch_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNTW         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic [WIDTH-1:0] fetch_addr,
    output logic             fetch_gnt,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_data,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_addr,
    output logic             load_gnt,
    output logic             load_valid,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata
);

    // state     | meaning
    // OWN_NONE  | no read issued last cycle, no response this cycle
    // OWN_FETCH | imem data this cycle belongs to the fetch requester
    // OWN_LOAD  | imem data this cycle belongs to the token loader
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

    owner_e           owner_q, owner_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [CNTW-1:0]  wait_cnt_q, wait_cnt_d;
    logic             force_load;
    logic             load_gnt_w;
    logic             fetch_gnt_w;

    // Grants depend only on requests and registered state; reset gates them off.
    assign force_load  = load_req && (wait_cnt_q == LIMIT);
    assign load_gnt_w  = reset && load_req && (force_load || !fetch_req);
    assign fetch_gnt_w = reset && fetch_req && !load_gnt_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            mem_addr_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        owner_d    = OWN_NONE;
        mem_addr_d = mem_addr_q;
        wait_cnt_d = '0;
        if (load_gnt_w) begin
            owner_d    = OWN_LOAD;
            mem_addr_d = load_addr;
        end else if (fetch_gnt_w) begin
            owner_d    = OWN_FETCH;
            mem_addr_d = fetch_addr;
        end
        // Saturate rather than wrap so a forced grant can never be missed.
        if (load_req && !load_gnt_w) begin
            wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        fetch_gnt   = fetch_gnt_w;
        load_gnt    = load_gnt_w;
        fetch_valid = (owner_q == OWN_FETCH);
        load_valid  = (owner_q == OWN_LOAD);
        fetch_data  = mem_rdata;
        load_data   = mem_rdata;
        mem_addr    = mem_addr_q;
    end

endmodule
